// File: rtl/kmap_pkg.sv
// Shared definitions for the K-map sweep controller.
//   sweep_state_t : sequencer states (IDLE -> RUN -> DONE -> IDLE)
//   N_IN_DEF      : default number of function inputs
//   tt_width(n)   : truth-table width for n inputs (2**n)
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_t;

  localparam int N_IN_DEF = 4;

  // One truth-table bit per input vector.
  function automatic int tt_width(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/kmap_result_acc.sv
// Result accumulator for the K-map sweep controller.
// Records each sampled function output, counts disagreements with the
// golden table and remembers the lowest failing vector index.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr           : clear all results (new sweep accepted)
//   sample_en     : capture fn_out for vector idx this edge
//   idx           : vector index being sampled
//   fn_out        : function unit output for vector idx
//   exp_bit       : golden output for vector idx
//   truth_table   : sampled outputs, bit i = fn_out for vector i
//   mismatch_cnt  : number of sampled vectors that disagreed
//   first_fail    : lowest disagreeing index (valid with fail_valid)
//   fail_valid    : at least one disagreement recorded
module kmap_result_acc
  import kmap_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            sample_en,
  input  logic [N_IN-1:0] idx,
  input  logic            fn_out,
  input  logic            exp_bit,
  output logic [TT_W-1:0] truth_table,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  // Vectors are swept in ascending order, so the first disagreement seen
  // is also the lowest failing index; later ones only bump the count.
  // The counter is one bit wider than idx, so even a fully failing sweep
  // (TT_W mismatches) cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      truth_table  <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_valid   <= 1'b0;
    end else if (sample_en) begin
      truth_table[idx] <= fn_out;
      if (fn_out != exp_bit) begin
        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
        if (!fail_valid) begin
          first_fail <= idx;
          fail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Sweep sequencer for a combinational K-map function unit.
// On an accepted start it drives every input vector in ascending order,
// holds each for SETTLE_CYCLES cycles, samples the unit output, and
// compares the resulting truth table against a latched golden table.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request a sweep (honoured only in IDLE, without abort)
//   abort         : cancel a running sweep
//   expected      : golden table, latched on accepted start
//   vec           : registered vector to the function unit ({a,b,c,d})
//   fn_out        : function unit output
//   busy          : sweep in progress
//   done          : one-cycle completion pulse (never on abort)
//   truth_table   : sampled outputs
//   mismatch_cnt  : number of disagreeing vectors
//   first_fail    : lowest disagreeing index (valid with fail_valid)
//   fail_valid    : at least one disagreement recorded
//   pass          : sweep completed with no disagreement
//   aborted       : last sweep was aborted
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = 1,
  localparam int TT_W         = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] vec,
  input  logic            fn_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] truth_table,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid,
  output logic            pass,
  output logic            aborted
);

  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]   IDX_LAST  = N_IN'(TT_W - 1);

  // A zero settle time would sample before the vector is ever driven.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("kmap_sweep_ctrl: SETTLE_CYCLES must be at least 1");
  end

  sweep_state_t      state;
  sweep_state_t      next_state;
  logic [N_IN-1:0]   idx;
  logic [SCNT_W-1:0] scnt;
  logic [TT_W-1:0]   exp_q;
  logic              accept;
  logic              do_abort;
  logic              sample_en;
  logic              finish;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. Abort is checked before the sample
  // condition so that an abort landing on the final sample edge
  // suppresses both the last sample and the done pulse.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    do_abort   = 1'b0;
    sample_en  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          do_abort   = 1'b1;
          next_state = IDLE;
        end else if (scnt == SCNT_LAST) begin
          sample_en = 1'b1;
          if (idx == IDX_LAST) begin
            finish     = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Sweep counters, golden-table latch and summary flags. vec is a
  // registered copy of idx so the function unit sees a clean vector from
  // the edge it is stepped; it keeps its last value once the sweep ends.
  // pass folds in the final sample directly, because mismatch_cnt only
  // reflects that sample one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      scnt    <= '0;
      vec     <= '0;
      exp_q   <= '0;
      pass    <= 1'b0;
      aborted <= 1'b0;
    end else if (accept) begin
      exp_q   <= expected;
      idx     <= '0;
      scnt    <= '0;
      vec     <= '0;
      pass    <= 1'b0;
      aborted <= 1'b0;
    end else if (do_abort) begin
      aborted <= 1'b1;
      pass    <= 1'b0;
    end else if (sample_en) begin
      scnt <= '0;
      if (finish) begin
        pass <= (mismatch_cnt == '0) && (fn_out == exp_q[idx]);
      end else begin
        idx <= idx + N_IN'(1);
        vec <= idx + N_IN'(1);
      end
    end else if (state == RUN) begin
      scnt <= scnt + SCNT_W'(1);
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  kmap_result_acc #(
    .N_IN (N_IN),
    .TT_W (TT_W)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .clr          (accept),
    .sample_en    (sample_en),
    .idx          (idx),
    .fn_out       (fn_out),
    .exp_bit      (exp_q[idx]),
    .truth_table  (truth_table),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail),
    .fail_valid   (fail_valid)
  );

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed testbench for kmap_sweep_ctrl.
// Two instances: dut (SETTLE_CYCLES=1) driving a selectable function unit
// (a&b or a^b^c^d), and dut3 (SETTLE_CYCLES=3) driving a parity unit.
module tb_kmap_sweep_ctrl;

  logic        clk;
  logic        rst;

  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [3:0]  vec;
  logic        fn_out;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;
  logic        fail_valid;
  logic        pass;
  logic        aborted;
  logic        fn_sel;

  logic        start3;
  logic        abort3;
  logic [15:0] expected3;
  logic [3:0]  vec3;
  logic        fn_out3;
  logic        busy3;
  logic        done3;
  logic [15:0] truth_table3;
  logic [4:0]  mismatch_cnt3;
  logic [3:0]  first_fail3;
  logic        fail_valid3;
  logic        pass3;
  logic        aborted3;

  int compared;
  int mismatched;
  int done_seen;

  // Behavioural function units: fn_sel=0 gives a&b, fn_sel=1 gives parity.
  assign fn_out  = fn_sel ? ^vec : (vec[3] & vec[2]);
  assign fn_out3 = ^vec3;

  kmap_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .vec          (vec),
    .fn_out       (fn_out),
    .busy         (busy),
    .done         (done),
    .truth_table  (truth_table),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail),
    .fail_valid   (fail_valid),
    .pass         (pass),
    .aborted      (aborted)
  );

  kmap_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .start        (start3),
    .abort        (abort3),
    .expected     (expected3),
    .vec          (vec3),
    .fn_out       (fn_out3),
    .busy         (busy3),
    .done         (done3),
    .truth_table  (truth_table3),
    .mismatch_cnt (mismatch_cnt3),
    .first_fail   (first_fail3),
    .fail_valid   (fail_valid3),
    .pass         (pass3),
    .aborted      (aborted3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [15:0] e);
    start    = s;
    abort    = a;
    expected = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] required);
    compared++;
    assert (observed === required)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, required);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    done_seen  = 0;
    rst        = 1'b1;
    fn_sel     = 1'b0;
    start3     = 1'b0;
    abort3     = 1'b0;
    expected3  = 16'h0000;
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_vec", 32'(vec), 32'd0);
    checkOutput("rst_tt", 32'(truth_table), 32'd0);
    checkOutput("rst_mcnt", 32'(mismatch_cnt), 32'd0);
    checkOutput("rst_ff", 32'(first_fail), 32'd0);
    checkOutput("rst_fv", 32'(fail_valid), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_aborted", 32'(aborted), 32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] sweep a&b against F000, S=1");
    applyStimulus(1'b1, 1'b0, 16'hF000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t1_busy_k", 32'(busy), 32'd1);
    checkOutput("t1_vec_k", 32'(vec), 32'd0);
    repeat (4) tick();
    checkOutput("t1_vec_k4", 32'(vec), 32'd4);
    repeat (11) tick();
    checkOutput("t1_done_k15", 32'(done), 32'd0);
    checkOutput("t1_busy_k15", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_done_k16", 32'(done), 32'd1);
    checkOutput("t1_busy_k16", 32'(busy), 32'd0);
    checkOutput("t1_tt", 32'(truth_table), 32'h0000_F000);
    checkOutput("t1_mcnt", 32'(mismatch_cnt), 32'd0);
    checkOutput("t1_fv", 32'(fail_valid), 32'd0);
    checkOutput("t1_pass", 32'(pass), 32'd1);
    tick();
    checkOutput("t1_done_k17", 32'(done), 32'd0);
    checkOutput("t1_vec_hold", 32'(vec), 32'd15);
    checkOutput("t1_pass_hold", 32'(pass), 32'd1);

    $display("[TB] sweep a&b against F001, S=1");
    applyStimulus(1'b1, 1'b0, 16'hF001);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t2_pass_clr", 32'(pass), 32'd0);
    repeat (16) tick();
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_tt", 32'(truth_table), 32'h0000_F000);
    checkOutput("t2_mcnt", 32'(mismatch_cnt), 32'd1);
    checkOutput("t2_ff", 32'(first_fail), 32'd0);
    checkOutput("t2_fv", 32'(fail_valid), 32'd1);
    checkOutput("t2_pass", 32'(pass), 32'd0);
    tick();

    $display("[TB] abort during parity sweep against 0000");
    fn_sel = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (5) tick();
    checkOutput("t4_busy_k5", 32'(busy), 32'd1);
    checkOutput("t4_vec_k5", 32'(vec), 32'd5);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t4_busy_k6", 32'(busy), 32'd0);
    checkOutput("t4_done_k6", 32'(done), 32'd0);
    checkOutput("t4_aborted", 32'(aborted), 32'd1);
    checkOutput("t4_pass", 32'(pass), 32'd0);
    checkOutput("t4_tt", 32'(truth_table), 32'h0000_0016);
    checkOutput("t4_mcnt", 32'(mismatch_cnt), 32'd3);
    checkOutput("t4_ff", 32'(first_fail), 32'd1);
    checkOutput("t4_fv", 32'(fail_valid), 32'd1);
    repeat (20) begin
      tick();
      if (done) done_seen++;
    end
    checkOutput("t4_no_done", 32'(done_seen), 32'd0);
    checkOutput("t4_vec_hold", 32'(vec), 32'd5);
    checkOutput("t4_tt_hold", 32'(truth_table), 32'h0000_0016);

    $display("[TB] start with abort in IDLE is ignored");
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("sa_busy", 32'(busy), 32'd0);
    checkOutput("sa_aborted", 32'(aborted), 32'd1);

    $display("[TB] back-to-back sweeps");
    fn_sel = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hF000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t6_aborted_clr", 32'(aborted), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    checkOutput("t6_fv_clr", 32'(fail_valid), 32'd0);
    checkOutput("t6_mcnt_clr", 32'(mismatch_cnt), 32'd0);
    repeat (16) tick();
    checkOutput("t6_done", 32'(done), 32'd1);
    checkOutput("t6_pass", 32'(pass), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0FFF);
    tick();
    checkOutput("t6_start_in_done_busy", 32'(busy), 32'd0);
    checkOutput("t6_done_fall", 32'(done), 32'd0);
    checkOutput("t6_pass_hold", 32'(pass), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t6_second_busy", 32'(busy), 32'd1);
    checkOutput("t6_second_pass_clr", 32'(pass), 32'd0);
    checkOutput("t6_second_vec", 32'(vec), 32'd0);

    $display("[TB] start while busy, then reset mid-sweep");
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t5_vec_k3", 32'(vec), 32'd3);
    checkOutput("t5_busy_k3", 32'(busy), 32'd1);
    repeat (4) tick();
    checkOutput("t5_mcnt_k7", 32'(mismatch_cnt), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_vec", 32'(vec), 32'd0);
    checkOutput("t5_tt", 32'(truth_table), 32'd0);
    checkOutput("t5_mcnt", 32'(mismatch_cnt), 32'd0);
    checkOutput("t5_ff", 32'(first_fail), 32'd0);
    checkOutput("t5_fv", 32'(fail_valid), 32'd0);
    checkOutput("t5_pass", 32'(pass), 32'd0);
    checkOutput("t5_aborted", 32'(aborted), 32'd0);
    tick();
    checkOutput("t5_idle_busy", 32'(busy), 32'd0);
    checkOutput("t5_idle_done", 32'(done), 32'd0);

    $display("[TB] parity sweep against 6996, S=3");
    start3    = 1'b1;
    expected3 = 16'h6996;
    tick();
    start3    = 1'b0;
    expected3 = 16'h0000;
    checkOutput("t3_busy_k", 32'(busy3), 32'd1);
    checkOutput("t3_vec_k", 32'(vec3), 32'd0);
    repeat (3) tick();
    checkOutput("t3_vec_k3", 32'(vec3), 32'd1);
    repeat (2) tick();
    checkOutput("t3_vec_k5", 32'(vec3), 32'd1);
    tick();
    checkOutput("t3_vec_k6", 32'(vec3), 32'd2);
    repeat (41) tick();
    checkOutput("t3_done_k47", 32'(done3), 32'd0);
    checkOutput("t3_busy_k47", 32'(busy3), 32'd1);
    tick();
    checkOutput("t3_done_k48", 32'(done3), 32'd1);
    checkOutput("t3_tt", 32'(truth_table3), 32'h0000_6996);
    checkOutput("t3_mcnt", 32'(mismatch_cnt3), 32'd0);
    checkOutput("t3_pass", 32'(pass3), 32'd1);
    tick();
    checkOutput("t3_done_k49", 32'(done3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
